// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM fade engine: channel mode
// encodings and the carrier period helper.
package pwm_pkg;

    typedef enum logic [1:0] {
        PWM_OFF   = 2'd0,
        PWM_CONST = 2'd1,
        PWM_TRI   = 2'd2,
        PWM_SAW   = 2'd3
    } pwm_mode_e;

    function automatic int pwm_period(input int clk_freq, input int pwm_freq);
        return clk_freq / pwm_freq;
    endfunction

endpackage

// File: rtl/pwm_fade_channel.sv
// One PWM fade channel: mode/bound/step registers, per-period duty update
// and the registered compare against the shared period counter.
module pwm_fade_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt,
    input  logic             wrap,
    input  logic             enable,
    input  logic             load,
    input  pwm_mode_e        load_mode,
    input  logic [WIDTH-1:0] load_min,
    input  logic [WIDTH-1:0] load_max,
    input  logic [WIDTH-1:0] load_step,
    output logic             pwm_out
);
    pwm_mode_e        mode;
    logic [WIDTH-1:0] min_q, max_q, step_q, duty;
    logic             dir;
    logic [WIDTH-1:0] duty_nxt;
    logic             dir_nxt;
    logic [WIDTH:0]   sum_up, lim_dn;

    // One extra bit so duty+step and min+step never wrap.
    assign sum_up = {1'b0, duty} + {1'b0, step_q};
    assign lim_dn = {1'b0, min_q} + {1'b0, step_q};

    always_comb begin
        duty_nxt = duty;
        dir_nxt  = dir;
        case (mode)
            PWM_CONST: duty_nxt = min_q;
            PWM_TRI: begin
                if (step_q != '0) begin
                    if (dir) begin
                        if (sum_up >= {1'b0, max_q}) begin
                            duty_nxt = max_q;
                            dir_nxt  = 1'b0;
                        end else begin
                            duty_nxt = sum_up[WIDTH-1:0];
                        end
                    end else begin
                        if ({1'b0, duty} <= lim_dn) begin
                            duty_nxt = min_q;
                            dir_nxt  = 1'b1;
                        end else begin
                            duty_nxt = duty - step_q;
                        end
                    end
                end
            end
            PWM_SAW: begin
                if (step_q != '0) begin
                    duty_nxt = (sum_up >= {1'b0, max_q}) ? min_q : sum_up[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode    <= PWM_OFF;
            min_q   <= '0;
            max_q   <= '0;
            step_q  <= '0;
            duty    <= '0;
            dir     <= 1'b1;
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= enable && (mode != PWM_OFF) && (cnt < duty);
            // A load only arrives on a wrap and replaces that period's fade step.
            if (load) begin
                mode   <= load_mode;
                min_q  <= load_min;
                max_q  <= load_max;
                step_q <= load_step;
                duty   <= load_min;
                dir    <= 1'b1;
            end else if (wrap) begin
                duty <= duty_nxt;
                dir  <= dir_nxt;
            end
        end
    end

endmodule

// File: rtl/pwm_fade_multi.sv
// Multi-channel PWM fade engine: shared period counter, one-entry config
// buffer applied at the period wrap, and CHANNELS fade channels.
module pwm_fade_multi
    import pwm_pkg::*;
#(
    parameter int  CLK_FREQ = 25_000_000,
    parameter int  PWM_FREQ = 1250,
    parameter int  CHANNELS = 8,
    parameter int  WIDTH    = 16,
    localparam int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [WIDTH-1:0]    cfg_min,
    input  logic [WIDTH-1:0]    cfg_max,
    input  logic [WIDTH-1:0]    cfg_step,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] pwm_out
);
    localparam int               PERIOD = pwm_period(CLK_FREQ, PWM_FREQ);
    localparam logic [WIDTH-1:0] LAST   = WIDTH'(PERIOD - 1);

    logic [WIDTH-1:0]    cnt;
    logic                wrap, fire, chan_ok, apply;
    logic                pend_valid;
    logic [CHAN_W-1:0]   pend_chan;
    pwm_mode_e           pend_mode;
    logic [WIDTH-1:0]    pend_min, pend_max, pend_step;
    logic [CHANNELS-1:0] load;

    // cfg_valid/cfg_ready: a write transfers on any cycle where both are high;
    // ready stays low while a captured write waits for the next wrap.
    assign wrap      = enable && (cnt == LAST);
    assign cfg_ready = !pend_valid;
    assign fire      = cfg_valid && cfg_ready;
    assign chan_ok   = (32'(cfg_chan) < 32'(CHANNELS));
    assign apply     = wrap && pend_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= wrap ? '0 : cnt + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_chan  <= '0;
            pend_mode  <= PWM_OFF;
            pend_min   <= '0;
            pend_max   <= '0;
            pend_step  <= '0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= fire && !chan_ok;
            // apply and fire never coincide: apply needs a full buffer, fire an empty one.
            if (apply) begin
                pend_valid <= 1'b0;
            end else if (fire && chan_ok) begin
                pend_valid <= 1'b1;
                pend_chan  <= cfg_chan;
                pend_mode  <= pwm_mode_e'(cfg_mode);
                pend_min   <= cfg_min;
                pend_max   <= (cfg_min > cfg_max) ? cfg_min : cfg_max;
                pend_step  <= cfg_step;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign load[g] = apply && (32'(pend_chan) == g);

        pwm_fade_channel #(.WIDTH(WIDTH)) u_chan (
            .clk       (clk),
            .rst       (rst),
            .cnt       (cnt),
            .wrap      (wrap),
            .enable    (enable),
            .load      (load[g]),
            .load_mode (pend_mode),
            .load_min  (pend_min),
            .load_max  (pend_max),
            .load_step (pend_step),
            .pwm_out   (pwm_out[g])
        );
    end

endmodule

// File: tb/tb_pwm_fade_multi.sv
// Bench for pwm_fade_multi (PERIOD=10, 4 channels) against a per-period duty
// model, plus a 5-channel instance for out-of-range channel writes.
module tb_pwm_fade_multi;
    localparam int CH = 4;
    localparam int P  = 10;

    logic          clk = 1'b0;
    logic          rst, enable, cfg_valid, cfg_ready, cfg_err;
    logic [1:0]    cfg_chan, cfg_mode;
    logic [15:0]   cfg_min, cfg_max, cfg_step;
    logic [CH-1:0] pwm_out;
    logic          cfg_valid2, cfg_ready2, cfg_err2;
    logic [2:0]    cfg_chan2;
    logic [4:0]    pwm_out2;

    int total = 0;
    int bad   = 0;

    typedef struct {int chan; int mode; int mn; int mx; int st;} wr_t;
    wr_t         pend_q[$];
    logic [15:0] exp_q[$];
    int          m_mode[CH], m_min[CH], m_max[CH], m_step[CH], m_duty[CH];
    bit          m_up[CH];
    int          m_cnt;

    pwm_fade_multi #(.CLK_FREQ(1000), .PWM_FREQ(100), .CHANNELS(4), .WIDTH(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_min(cfg_min), .cfg_max(cfg_max),
        .cfg_step(cfg_step), .cfg_err(cfg_err), .pwm_out(pwm_out)
    );

    pwm_fade_multi #(.CLK_FREQ(1000), .PWM_FREQ(100), .CHANNELS(5), .WIDTH(16)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
        .cfg_chan(cfg_chan2), .cfg_mode(cfg_mode), .cfg_min(cfg_min), .cfg_max(cfg_max),
        .cfg_step(cfg_step), .cfg_err(cfg_err2), .pwm_out(pwm_out2)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        pend_q.delete();
        m_cnt = 0;
        for (int i = 0; i < CH; i++) begin
            m_mode[i] = 0; m_min[i] = 0; m_max[i] = 0; m_step[i] = 0; m_duty[i] = 0; m_up[i] = 1;
        end
    endfunction

    // Duty rule applied once per completed period.
    function automatic void model_fade(int i);
        case (m_mode[i])
            1: m_duty[i] = m_min[i];
            2: if (m_step[i] != 0) begin
                if (m_up[i]) begin
                    if (m_duty[i] + m_step[i] >= m_max[i]) begin m_duty[i] = m_max[i]; m_up[i] = 0; end
                    else m_duty[i] = m_duty[i] + m_step[i];
                end else begin
                    if (m_duty[i] <= m_min[i] + m_step[i]) begin m_duty[i] = m_min[i]; m_up[i] = 1; end
                    else m_duty[i] = m_duty[i] - m_step[i];
                end
            end
            3: if (m_step[i] != 0)
                m_duty[i] = (m_duty[i] + m_step[i] >= m_max[i]) ? m_min[i] : m_duty[i] + m_step[i];
            default: ;
        endcase
    endfunction

    // Advance one clock. ep: pwm_out expected after the edge; er: cfg_ready
    // expected after the edge; cp: model count during the cycle just clocked.
    task automatic tick(output logic [CH-1:0] ep, output logic er, output int cp);
        bit  wrap, fire;
        wr_t w, a;
        cp   = m_cnt;
        wrap = enable && (m_cnt == P - 1);
        fire = cfg_valid && (pend_q.size() == 0);
        for (int i = 0; i < CH; i++) ep[i] = enable && (m_mode[i] != 0) && (m_cnt < m_duty[i]);
        w.chan = int'(cfg_chan); w.mode = int'(cfg_mode); w.mn = int'(cfg_min);
        w.mx = (cfg_min > cfg_max) ? int'(cfg_min) : int'(cfg_max); w.st = int'(cfg_step);
        @(posedge clk);
        if (wrap) begin
            for (int i = 0; i < CH; i++) model_fade(i);
            if (pend_q.size() != 0) begin
                a = pend_q.pop_front();
                m_mode[a.chan] = a.mode; m_min[a.chan] = a.mn; m_max[a.chan] = a.mx;
                m_step[a.chan] = a.st; m_duty[a.chan] = a.mn; m_up[a.chan] = 1;
            end
        end
        if (fire) pend_q.push_back(w);
        if (enable) m_cnt = wrap ? 0 : m_cnt + 1;
        @(negedge clk);
        er = (pend_q.size() == 0);
    endtask

    task automatic do_write(input int ch, input int md, input int mn, input int mx, input int st,
                            output logic [CH-1:0] ep, output logic er, output int cp);
        cfg_chan = 2'(ch); cfg_mode = 2'(md);
        cfg_min = 16'(mn); cfg_max = 16'(mx); cfg_step = 16'(st);
        cfg_valid = 1'b1;
        tick(ep, er, cp);
        cfg_valid = 1'b0;
    endtask

    // Step until the cycle just clocked was the last of a period.
    task automatic sync_wrap(output bit ok);
        logic [CH-1:0] ep; logic er; int cp; int n;
        n = 0;
        do begin tick(ep, er, cp); n++; end while (cp != P - 1 && n < 3 * P);
        ok = (cp == P - 1);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_valid2 = 1'b0;
        cfg_chan = '0; cfg_chan2 = '0; cfg_mode = '0; cfg_min = '0; cfg_max = '0; cfg_step = '0;
        repeat (2) @(negedge clk);
        total++; if (pwm_out !== 4'b0) begin bad++; $display("FAIL reset_pwm got=%b want=0000", pwm_out); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cfg_ready); end
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", cfg_err); end
        model_reset();
        rst = 1'b0; enable = 1'b1;
    endtask

    task automatic test_idle();
        logic [CH-1:0] ep; logic er; int cp;
        for (int k = 0; k < 2 * P; k++) begin
            tick(ep, er, cp);
            total++;
            if (pwm_out !== 4'b0 || cfg_ready !== 1'b1 || pwm_out !== ep || cfg_ready !== er) begin
                bad++; $display("FAIL idle k=%0d pwm=%b want=%b rdy=%b want=%b", k, pwm_out, ep, cfg_ready, er);
            end
        end
    endtask

    task automatic test_const();
        logic [CH-1:0] ep; logic er; int cp; bit ok; int hi[CH];
        do_write(1, 1, 3, 3, 0, ep, er, cp);
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL const_ready_low got=%b want=0", cfg_ready); end
        sync_wrap(ok);
        total++; if (!ok || cfg_ready !== 1'b1) begin bad++; $display("FAIL const_ready_back ok=%0d got=%b want=1", ok, cfg_ready); end
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < CH; i++) hi[i] = 0;
            for (int c = 0; c < P; c++) begin
                tick(ep, er, cp);
                total++;
                if (pwm_out !== ep || pwm_out[1] !== (cp < 3)) begin
                    bad++; $display("FAIL const_cycle cnt=%0d pwm=%b want=%b", cp, pwm_out, ep);
                end
                for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
            end
            total++;
            if (hi[0] != 0 || hi[1] != 3 || hi[2] != 0 || hi[3] != 0) begin
                bad++; $display("FAIL const_period p=%0d got=%0d,%0d,%0d,%0d want=0,3,0,0", p, hi[0], hi[1], hi[2], hi[3]);
            end
        end
    endtask

    // Write a fading channel and compare per-period high counts with exp_q.
    task automatic test_ramp(input string name, input int ch, input int md, input int mn,
                             input int mx, input int st);
        logic [CH-1:0] ep; logic er; int cp; bit ok; int hi; int np;
        do_write(ch, md, mn, mx, st, ep, er, cp);
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL %s_ready_low got=%b want=0", name, cfg_ready); end
        sync_wrap(ok);
        total++; if (!ok || cfg_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_back ok=%0d got=%b want=1", name, ok, cfg_ready); end
        np = exp_q.size();
        for (int p = 0; p < np; p++) begin
            hi = 0;
            for (int c = 0; c < P; c++) begin
                tick(ep, er, cp);
                total++;
                if (pwm_out !== ep || cfg_ready !== er) begin
                    bad++; $display("FAIL %s_cycle cnt=%0d pwm=%b want=%b rdy=%b want=%b", name, cp, pwm_out, ep, cfg_ready, er);
                end
                hi += int'(pwm_out[ch]);
            end
            total++;
            if (hi != int'(exp_q[0])) begin
                bad++; $display("FAIL %s_duty p=%0d got=%0d want=%0d", name, p, hi, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_bad_addr();
        logic [CH-1:0] ep; logic er; int cp;
        cfg_chan2 = 3'd5; cfg_mode = 2'd1; cfg_min = 16'd5; cfg_max = 16'd5; cfg_step = 16'd0;
        cfg_valid2 = 1'b1;
        total++; if (cfg_err2 !== 1'b0) begin bad++; $display("FAIL bad_err_early got=%b want=0", cfg_err2); end
        tick(ep, er, cp);
        cfg_valid2 = 1'b0;
        total++; if (cfg_err2 !== 1'b1) begin bad++; $display("FAIL bad_err_pulse got=%b want=1", cfg_err2); end
        total++; if (cfg_ready2 !== 1'b1) begin bad++; $display("FAIL bad_ready got=%b want=1", cfg_ready2); end
        tick(ep, er, cp);
        total++; if (cfg_err2 !== 1'b0) begin bad++; $display("FAIL bad_err_clear got=%b want=0", cfg_err2); end
        for (int k = 0; k < 2 * P; k++) begin
            tick(ep, er, cp);
            total++;
            if (pwm_out2 !== 5'b0 || cfg_ready2 !== 1'b1 || cfg_err2 !== 1'b0) begin
                bad++; $display("FAIL bad_quiet k=%0d pwm=%b want=00000 rdy=%b err=%b", k, pwm_out2, cfg_ready2, cfg_err2);
            end
        end
    endtask

    task automatic test_freeze();
        logic [CH-1:0] ep; logic er; int cp; bit ok;
        sync_wrap(ok);
        total++; if (!ok) begin bad++; $display("FAIL freeze_sync got=0 want=1"); end
        repeat (4) tick(ep, er, cp);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(ep, er, cp);
            total++;
            if (pwm_out !== 4'b0 || pwm_out !== ep || cp != 4) begin
                bad++; $display("FAIL freeze_hold k=%0d pwm=%b want=0000 cnt=%0d", k, pwm_out, cp);
            end
        end
        enable = 1'b1;
        for (int k = 0; k < 2 * P; k++) begin
            tick(ep, er, cp);
            total++;
            if (pwm_out !== ep || cfg_ready !== er) begin
                bad++; $display("FAIL freeze_resume k=%0d pwm=%b want=%b", k, pwm_out, ep);
            end
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] ep; logic er; int cp;
        for (int k = 0; k < 600; k++) begin
            enable    = ($urandom_range(0, 11) != 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_chan  = 2'($urandom_range(0, 3));
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_min   = 16'($urandom_range(0, 12));
            cfg_max   = 16'($urandom_range(0, 12));
            cfg_step  = 16'($urandom_range(0, 5));
            tick(ep, er, cp);
            total++;
            if (pwm_out !== ep || cfg_ready !== er || cfg_err !== 1'b0) begin
                bad++; $display("FAIL random k=%0d pwm=%b want=%b rdy=%b want=%b err=%b", k, pwm_out, ep, cfg_ready, er, cfg_err);
            end
        end
        cfg_valid = 1'b0; enable = 1'b1;
    endtask

    task automatic test_reset_pending();
        logic [CH-1:0] ep; logic er; int cp; bit ok;
        sync_wrap(ok);
        do_write(0, 2, 1, 9, 1, ep, er, cp);
        total++; if (!ok || cfg_ready !== 1'b0) begin bad++; $display("FAIL rstp_pending got=%b want=0", cfg_ready); end
        rst = 1'b1;
        #1;
        total++;
        if (pwm_out !== 4'b0 || cfg_ready !== 1'b1) begin
            bad++; $display("FAIL rstp_clear pwm=%b want=0000 rdy=%b want=1", pwm_out, cfg_ready);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3 * P; k++) begin
            tick(ep, er, cp);
            total++;
            if (pwm_out !== 4'b0 || cfg_ready !== 1'b1 || pwm_out !== ep) begin
                bad++; $display("FAIL rstp_lost k=%0d pwm=%b want=0000 rdy=%b want=1", k, pwm_out, cfg_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_const();
        exp_q = '{16'd2, 16'd5, 16'd8, 16'd5, 16'd2, 16'd5};
        test_ramp("tri", 0, 2, 2, 8, 3);
        exp_q = '{16'd0, 16'd4, 16'd8, 16'd0, 16'd4, 16'd8};
        test_ramp("saw4", 2, 3, 0, 10, 4);
        exp_q = '{16'd0, 16'd5, 16'd0, 16'd5};
        test_ramp("saw5", 2, 3, 0, 10, 5);
        exp_q = '{16'd7, 16'd7, 16'd7};
        test_ramp("clamp", 3, 2, 7, 4, 2);
        test_bad_addr();
        test_freeze();
        test_random();
        test_reset_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
